// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg : shared constants, FSM encodings and IF/ID record types
// Revision : 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] C_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] C_EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] C_NOP        = 32'h0000_0000;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] S_HOLD = 2'd3;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } fetch_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        adel;
        logic        ds;
    } if_id_t;

    function automatic if_id_t make_if_id(input fetch_t e, input logic ds);
        if_id_t r;
        r.valid = 1'b1;
        r.inst  = e.inst;
        r.pc    = e.pc;
        r.pc8   = e.pc + 32'd8;
        r.adel  = e.adel;
        r.ds    = ds;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_id_reg : IF/ID pipeline register with stall, flush and one-entry skid
// Revision  : 1.0
// ----------------------------------------------------------------------------
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  logic   stall_i,
    input  logic   fill_i,
    input  fetch_t fill_data_i,
    input  logic   pop_i,
    input  logic   ds_i,
    output if_id_t id_o
);

    if_id_t id_q, id_d;
    fetch_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q         <= '0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            id_q         <= id_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Unstalled cycles with nothing to deliver load a bubble.
    always_comb begin
        id_d         = id_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            id_d         = '0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (!stall_i) begin
            if (pop_i && skid_valid_q) begin
                id_d         = make_if_id(skid_q, ds_i);
                skid_valid_d = 1'b0;
            end else if (fill_i) begin
                id_d = make_if_id(fill_data_i, ds_i);
            end else begin
                id_d = '0;
            end
        end else if (fill_i) begin
            skid_d       = fill_data_i;
            skid_valid_d = 1'b1;
        end
    end

    assign id_o = id_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_fetch_stage : MIPS IF stage - PC, next-PC select, imem port, IF/ID reg
// Revision       : 1.0
// ----------------------------------------------------------------------------
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = C_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = C_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        pc_change,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_adel,
    output logic        id_in_delay_slot
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               pend_q, pend_d;
    logic [31:0]        ptgt_q, ptgt_d;

    logic        flush;
    logic [31:0] flush_tgt;
    logic        br_now;
    logic        misaligned;
    logic        rsp_ok;
    logic        complete;
    logic [31:0] next_seq;
    logic        fill;
    fetch_t      fill_data;
    logic        pop;
    logic        ds;
    if_id_t      id;

    assign flush      = exc_valid | eret_valid;
    assign flush_tgt  = exc_valid ? EXC_VECTOR : epc;
    assign br_now     = pc_change & ~flush;
    assign misaligned = |pc_q[1:0];
    assign rsp_ok     = (state_q == S_WAIT) & imem_rvalid & ~kill_q;
    assign complete   = ~flush & ~stall & (rsp_ok | (state_q == S_HOLD));
    // A branch only takes effect once its delay-slot fetch has completed.
    assign next_seq   = (br_now | pend_q) ? (pc_change ? redirect_pc : ptgt_q)
                                          : pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        pend_d  = pend_q | br_now;
        ptgt_d  = br_now ? redirect_pc : ptgt_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (!misaligned) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = (kill_q || !stall) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: if (!stall) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        if (complete) begin
            pc_d   = next_seq;
            pend_d = 1'b0;
        end
        // A request issued this cycle or still outstanding must be discarded.
        if (flush) begin
            pc_d   = flush_tgt;
            pend_d = 1'b0;
            unique case (state_q)
                S_REQ:  if (!misaligned) kill_d = 1'b1;
                S_WAIT: begin
                    if (imem_rvalid) state_d = S_REQ;
                    else             kill_d  = 1'b1;
                end
                S_HOLD: state_d = S_REQ;
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_req       = (state_q == S_REQ) & ~misaligned;
        imem_addr      = (state_q == S_REQ) ? pc_q : 32'h0;
        fill           = rsp_ok | ((state_q == S_REQ) & misaligned & ~stall);
        fill_data.pc   = pc_q;
        fill_data.inst = (state_q == S_REQ) ? C_NOP : imem_rdata;
        fill_data.adel = (state_q == S_REQ);
        pop            = (state_q == S_HOLD);
        ds             = pend_q | br_now;
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .stall_i     (stall),
        .fill_i      (fill),
        .fill_data_i (fill_data),
        .pop_i       (pop),
        .ds_i        (ds),
        .id_o        (id)
    );

    assign id_valid         = id.valid;
    assign id_inst          = id.inst;
    assign id_pc            = id.pc;
    assign id_pc8           = id.pc8;
    assign id_adel          = id.adel;
    assign id_in_delay_slot = id.ds;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_if_fetch_stage : directed table-driven bench for if_fetch_stage
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, exc_valid, eret_valid, pc_change;
    logic [31:0] epc, redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid, id_adel, id_in_delay_slot;
    logic [31:0] id_inst, id_pc, id_pc8;

    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = 32'h0;
    logic        man_rvalid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // One-cycle memory whose content at each address is the address itself.
    always @(posedge clk) begin
        m_rvalid <= imem_req;
        m_rdata  <= imem_addr;
    end
    assign imem_rvalid = m_rvalid | man_rvalid;
    assign imem_rdata  = man_rvalid ? 32'hDEAD_BEEF : m_rdata;

    if_fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .exc_valid        (exc_valid),
        .eret_valid       (eret_valid),
        .epc              (epc),
        .pc_change        (pc_change),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .id_valid         (id_valid),
        .id_inst          (id_inst),
        .id_pc            (id_pc),
        .id_pc8           (id_pc8),
        .id_adel          (id_adel),
        .id_in_delay_slot (id_in_delay_slot)
    );

    typedef struct {
        logic        stall;
        logic        pcc;
        logic        exc;
        logic        eret;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ds;
        logic        adel;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic st, input logic pcc, input logic exc,
                                input logic eret, input logic [31:0] tgt,
                                input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] inst,
                                input logic [31:0] pc, input logic ds, input logic adel);
        vec_t r;
        r.stall = st;  r.pcc = pcc; r.exc = exc; r.eret = eret; r.tgt = tgt;
        r.req = req;   r.addr = addr; r.v = v; r.inst = inst; r.pc = pc;
        r.ds = ds;     r.adel = adel;
        return r;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_outs(input int row, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [31:0] pc8,
                              input logic ds, input logic adel);
        check("imem_req",  row, 32'(imem_req), 32'(req));
        check("imem_addr", row, imem_addr, addr);
        check("id_valid",  row, 32'(id_valid), 32'(v));
        check("id_inst",   row, id_inst, inst);
        check("id_pc",     row, id_pc, pc);
        check("id_pc8",    row, id_pc8, pc8);
        check("id_ds",     row, 32'(id_in_delay_slot), 32'(ds));
        check("id_adel",   row, 32'(id_adel), 32'(adel));
    endtask

    initial begin
        //                 st pcc exc eret tgt           req addr          v  inst          pc            ds adel
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,         1, 32'hBFC00000, 0, 32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         1, 32'hBFC00004, 1, 32'hBFC00000, 32'hBFC00000, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 32'hBFC00100,  1, 32'hBFC00008, 1, 32'hBFC00004, 32'hBFC00004, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         1, 32'hBFC00100, 1, 32'hBFC00008, 32'hBFC00008, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 32'h0,         1, 32'hBFC00104, 1, 32'hBFC00100, 32'hBFC00100, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hBFC00100, 32'hBFC00100, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hBFC00100, 32'hBFC00100, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hBFC00100, 32'hBFC00100, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hBFC00100, 32'hBFC00100, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hBFC00100, 32'hBFC00100, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 32'h0,         1, 32'hBFC00108, 1, 32'hBFC00104, 32'hBFC00104, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,         1, 32'hBFC00380, 0, 32'h0,        32'h0,        0, 0);
        vecs[17] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[18] = mk(1, 0, 0, 0, 32'h0,         1, 32'hBFC00384, 1, 32'hBFC00380, 32'hBFC00380, 0, 0);
        vecs[19] = mk(1, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'hBFC00380, 32'hBFC00380, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,         1, 32'hBFC00380, 0, 32'h0,        32'h0,        0, 0);
        vecs[21] = mk(0, 0, 0, 1, 32'hBFC00102,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[22] = mk(0, 0, 0, 0, 32'h0,         0, 32'hBFC00102, 0, 32'h0,        32'h0,        0, 0);
        vecs[23] = mk(0, 0, 1, 0, 32'h0,         0, 32'hBFC00102, 1, 32'h0,        32'hBFC00102, 0, 1);
        vecs[24] = mk(0, 0, 0, 1, 32'hFFFFFFFC,  1, 32'hBFC00380, 0, 32'h0,        32'h0,        0, 0);
        vecs[25] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[26] = mk(0, 0, 0, 0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        0, 0);
        vecs[27] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[28] = mk(0, 0, 0, 0, 32'h0,         1, 32'h00000000, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0);

        rst = 1'b1; stall = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
        pc_change = 1'b0; epc = 32'h0; redirect_pc = 32'h0; man_rvalid = 1'b0;

        repeat (2) @(negedge clk);
        check_outs(-1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            stall       = vecs[i].stall;
            pc_change   = vecs[i].pcc;
            redirect_pc = vecs[i].tgt;
            exc_valid   = vecs[i].exc;
            eret_valid  = vecs[i].eret;
            epc         = vecs[i].tgt;
            check_outs(i, vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].inst,
                       vecs[i].pc, vecs[i].v ? vecs[i].pc + 32'd8 : 32'h0,
                       vecs[i].ds, vecs[i].adel);
        end

        // Asynchronous reset while the fetch at address 0 is outstanding.
        @(negedge clk);
        stall = 1'b0; pc_change = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_outs(100, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        man_rvalid = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b0;
        check_outs(101, 1, 32'hBFC00000, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_outs(102, 1, 32'hBFC00004, 1, 32'hBFC00000, 32'hBFC00000, 32'hBFC00008, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
